// File: rtl/press_repeat_pkg.sv
// Shared types and helpers for the press/repeat detector: channel state
// encoding and the counter-width rule used by every counter in the block.
package press_repeat_pkg;

  typedef enum logic [1:0] {
    StLocked = 2'd0,
    StIdle   = 2'd1,
    StHeld   = 2'd2,
    StRepeat = 2'd3
  } state_e;

  // Counters hold 0..n-1; a degenerate range still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/press_repeat_detector_if.sv
// Button-level input and per-channel event outputs of the detector.
// The detector takes the slave side; the upstream/consumer takes the master side.
interface press_repeat_detector_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] debounced_signal;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;
  logic [WIDTH-1:0] repeat_pulse;
  logic [WIDTH-1:0] long_press;

  modport master (
    output debounced_signal,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse,
    input  long_press
  );

  modport slave (
    input  debounced_signal,
    output press_pulse,
    output release_pulse,
    output repeat_pulse,
    output long_press
  );

endinterface

// File: rtl/press_repeat_channel.sv
// One button channel: LOCKED/IDLE/HELD/REPEAT state machine with hold and
// repeat tick counters; all outputs registered.
module press_repeat_channel
  import press_repeat_pkg::*;
#(
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_press
);

  localparam int unsigned HoldW    = cnt_width(HOLD_TICKS);
  localparam int unsigned RepW     = cnt_width(REPEAT_TICKS);
  localparam bit          RepeatEn = (REPEAT_TICKS > 0);
  localparam int unsigned RepLast  = RepeatEn ? REPEAT_TICKS - 1 : 0;

  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TICKS - 1);
  localparam logic [RepW-1:0]  RepTerm  = RepW'(RepLast);

  state_e           state;
  logic [HoldW-1:0] hold_cnt;
  logic [RepW-1:0]  rep_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StLocked;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        // A level held through reset must be seen low before it can count.
        StLocked: begin
          if (!din) state <= StIdle;
        end

        StIdle: begin
          if (din) begin
            state       <= StHeld;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
          end
        end

        StHeld: begin
          if (!din) begin
            state         <= StIdle;
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
          end else if (tick) begin
            if (hold_cnt == HoldLast) begin
              state        <= StRepeat;
              repeat_pulse <= 1'b1;
              long_press   <= 1'b1;
              hold_cnt     <= '0;
              rep_cnt      <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        // Release is checked first so it beats a same-edge repeat expiry.
        StRepeat: begin
          if (!din) begin
            state         <= StIdle;
            release_pulse <= 1'b1;
            long_press    <= 1'b0;
            rep_cnt       <= '0;
          end else if (RepeatEn && tick) begin
            if (rep_cnt == RepTerm) begin
              repeat_pulse <= 1'b1;
              rep_cnt      <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= StLocked;
        end
      endcase
    end
  end

endmodule

// File: rtl/press_repeat_detector.sv
// Press/release/auto-repeat detector: one free-running tick prescaler shared
// by WIDTH independent channel state machines.
module press_repeat_detector
  import press_repeat_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned TICK_CYCLES  = 125000,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input logic                   clk,
  input logic                   rst_n,
  press_repeat_detector_if.slave bus
);

  localparam int unsigned     TickW    = cnt_width(TICK_CYCLES);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);

  logic [TickW-1:0] tick_cnt;
  logic             tick;

  logic [WIDTH-1:0] press_vec;
  logic [WIDTH-1:0] release_vec;
  logic [WIDTH-1:0] repeat_vec;
  logic [WIDTH-1:0] long_vec;

  // Prescaler never restarts on channel activity, so tick phase is global.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TickLast);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    press_repeat_channel #(
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .din           (bus.debounced_signal[i]),
      .press_pulse   (press_vec[i]),
      .release_pulse (release_vec[i]),
      .repeat_pulse  (repeat_vec[i]),
      .long_press    (long_vec[i])
    );
  end

  assign bus.press_pulse   = press_vec;
  assign bus.release_pulse = release_vec;
  assign bus.repeat_pulse  = repeat_vec;
  assign bus.long_press    = long_vec;

endmodule

// File: tb/tb_press_repeat_detector.sv
// Directed, table-driven bench for press_repeat_detector with
// WIDTH=2, TICK_CYCLES=4, HOLD_TICKS=3, REPEAT_TICKS=2.
module tb_press_repeat_detector;

  logic clk;
  logic rst_n;

  press_repeat_detector_if #(.WIDTH(2)) bus ();

  press_repeat_detector #(
    .WIDTH        (2),
    .TICK_CYCLES  (4),
    .HOLD_TICKS   (3),
    .REPEAT_TICKS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record covers n consecutive cycles with the same input and outputs.
  typedef struct {
    logic [1:0]  din;
    int unsigned n;
    logic [1:0]  prs;
    logic [1:0]  rel;
    logic [1:0]  rpt;
    logic [1:0]  lng;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;
  int   split_idx;

  function automatic void add(input logic [1:0] din, input int unsigned n,
                              input logic [1:0] prs, input logic [1:0] rel,
                              input logic [1:0] rpt, input logic [1:0] lng);
    vec_t v;
    v.din = din; v.n = n; v.prs = prs; v.rel = rel; v.rpt = rpt; v.lng = lng;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] exp);
    logic [7:0] got;
    got = {bus.press_pulse, bus.release_pulse, bus.repeat_pulse, bus.long_press};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d t=%0t got{prs,rel,rpt,lng}=%b expected=%b",
               name, idx, $time, got, exp);
    end
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i < last; i++) begin
      for (int c = 0; c < int'(vecs[i].n); c++) begin
        bus.debounced_signal = vecs[i].din;
        @(posedge clk);
        @(negedge clk);
        check("vec", i, {vecs[i].prs, vecs[i].rel, vecs[i].rpt, vecs[i].lng});
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Ticks land on posedges 4, 8, 12, ... counted from reset release.
    add(2'b01, 40, 2'b00, 2'b00, 2'b00, 2'b00); // held through reset: locked
    add(2'b00,  1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b00, 2'b00); // P42 press
    add(2'b01,  4, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b00); // P47 short release
    add(2'b00,  3, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b00, 2'b00); // P51 press
    add(2'b01,  8, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b00, 2'b00, 2'b01, 2'b01); // P60 long-press entry
    add(2'b01,  7, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b01,  1, 2'b00, 2'b00, 2'b01, 2'b01); // P68 repeat
    add(2'b01,  7, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b01,  1, 2'b00, 2'b00, 2'b01, 2'b01); // P76 repeat
    add(2'b01,  7, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b01,  1, 2'b00, 2'b00, 2'b01, 2'b01); // P84 repeat
    add(2'b01,  6, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b00); // P91 release, long falls
    add(2'b00,  5, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b00, 2'b00); // P97 press
    add(2'b01, 10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b00); // P108 release on expiry tick
    add(2'b00,  3, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b11,  1, 2'b11, 2'b00, 2'b00, 2'b00); // P112 dual press
    add(2'b11,  5, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b00, 2'b10, 2'b00, 2'b00); // P118 bit1 release
    add(2'b01,  5, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b00, 2'b00, 2'b01, 2'b01); // P124 bit0 long-press
    add(2'b01,  7, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b01,  1, 2'b00, 2'b00, 2'b01, 2'b01); // P132 repeat, reset follows
    split_idx = vecs.size();
    add(2'b01, 10, 2'b00, 2'b00, 2'b00, 2'b00); // still held after reset
    add(2'b00,  1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b00);

    rst_n = 1'b0;
    bus.debounced_signal = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", -1, 8'h00);
    rst_n = 1'b1;

    run_vecs(0, split_idx);

    // Asynchronous reset while repeat_pulse and long_press are high.
    if (bus.repeat_pulse !== 2'b01) begin
      $display("FAIL pre_reset_pulse got=%b expected=01", bus.repeat_pulse);
      failures++;
    end
    checks++;
    rst_n = 1'b0;
    #1;
    check("async_reset", -2, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("reset_held", -3, 8'h00);
    rst_n = 1'b1;

    run_vecs(split_idx, vecs.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/press_repeat_detector.md
# press_repeat_detector

Converts a bus of debounced, synchronized button levels into single-cycle press, release and auto-repeat pulses plus a long-press level. Sits directly downstream of the debouncer in the io_circuits chain. Its outputs feed CPU-visible MMIO button status and the UI logic. One shared millisecond-scale tick prescaler times all channels; each channel runs an independent state machine.

## Interface
- WIDTH, 1: number of independent button channels.
- TICK_CYCLES, 125000: clk cycles per timing tick (1 ms at 125 MHz); must be ≥ 2.
- HOLD_TICKS, 500: ticks a press must be held before long-press; must be ≥ 2.
- REPEAT_TICKS, 100: ticks between auto-repeat pulses; 0 disables periodic repeats.
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- debounced_signal  input  WIDTH  debounced button levels, already synchronous to clk.
- press_pulse  output  WIDTH  one-cycle pulse per accepted press.
- release_pulse  output  WIDTH  one-cycle pulse per release of an accepted press.
- repeat_pulse  output  WIDTH  one-cycle pulse at long-press entry and at each repeat period.
- long_press  output  WIDTH  level; high while a held press is past HOLD_TICKS.

## Operation
- Prescaler: tick_cnt counts 0..TICK_CYCLES-1 and wraps. tick is high for one cycle when tick_cnt == TICK_CYCLES-1. Free-running, shared by all channels, never reset by channel activity.
- Per-channel states: LOCKED, IDLE, HELD, REPEAT. Transitions are evaluated on each rising clk edge; "in" means debounced_signal[i] at that edge.
- LOCKED (reset state): in=0 → IDLE. in=1 → stay. A button held through reset never produces press_pulse.
- IDLE: in=1 → HELD, press_pulse=1, hold_cnt=0.
- HELD: in=0 → IDLE, release_pulse=1. Otherwise each tick increments hold_cnt. A tick with hold_cnt == HOLD_TICKS-1 → REPEAT, repeat_pulse=1, long_press=1, rep_cnt=0.
- REPEAT: in=0 → IDLE, release_pulse=1, long_press=0. Otherwise, if REPEAT_TICKS>0, each tick increments rep_cnt. A tick with rep_cnt == REPEAT_TICKS-1 → repeat_pulse=1, rep_cnt=0.
- Release beats a same-edge tick expiry: no repeat_pulse, counters cleared.
- Counter widths: hold_cnt $clog2(HOLD_TICKS), rep_cnt $clog2(REPEAT_TICKS) (min 1), tick_cnt $clog2(TICK_CYCLES). No counter exceeds its terminal value.
- Channels are fully independent. Simultaneous events on different bits are all reported in the same cycle.

## Timing
- All outputs are registered. A pulse is high exactly one cycle, in the cycle after the edge that caused it.
- Press latency: in rises and is sampled at edge t → press_pulse high during cycle t+1.
- Long-press latency from press: between (HOLD_TICKS-1)·TICK_CYCLES+1 and HOLD_TICKS·TICK_CYCLES cycles, depending on tick phase.
- Repeat period: exactly REPEAT_TICKS·TICK_CYCLES cycles between repeat_pulses.
- long_press rises in the same cycle as the first repeat_pulse. It falls in the same cycle as release_pulse.
- Reset assertion at any time asynchronously clears all outputs, counters and tick_cnt to 0 and puts every channel in LOCKED, including mid-pulse and mid-hold.
- Reset values: press_pulse, release_pulse, repeat_pulse, long_press all 0.

## Structure
- Shared package press_repeat_pkg: state encodings (LOCKED=0, IDLE=1, HELD=2, REPEAT=3, 2-bit) and the counter-width helper constants.
- Sub-module press_repeat_channel: one-bit FSM plus hold_cnt/rep_cnt. Instantiated WIDTH times via generate.
- Top level holds only the prescaler and the tick fan-out.

## Test plan
Use WIDTH=2, TICK_CYCLES=4, HOLD_TICKS=3, REPEAT_TICKS=2.
- rst_n low with in=2'b01, then release reset and hold in for 40 cycles → no outputs. Drop bit0 then raise it → press_pulse[0] once, one cycle after the sampled rise.
- Raise bit0 for 5 cycles then drop → press_pulse=01, then release_pulse=01; repeat_pulse and long_press stay 0.
- Hold bit0 for 40 cycles → first repeat_pulse and long_press rise 9–12 cycles after press. Further repeat_pulses follow every 8 cycles. Release → long_press falls with release_pulse.
- Release bit0 on the exact edge where the hold tick would expire → release_pulse only, no repeat_pulse, long_press stays 0.
- Press bit0 and bit1 on the same edge, release bit1 after 6 cycles → press_pulse=11 in one cycle. Bit0 later reaches long-press unaffected.
- Assert rst_n low mid-REPEAT with in held → all outputs 0 immediately. After reset release, no press is reported until in goes low and then high again.
